// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with busy scoreboard and sweeping clear engine.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module register_file_mp #(
    parameter int XLEN            = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int NUM_READ_PORTS  = 2,
    parameter int NUM_WRITE_PORTS = 2
) (
    input  logic                                      i_Clock,
    input  logic                                      i_Reset_N,
    input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0]  i_Read_Addr,
    output logic [NUM_READ_PORTS*XLEN-1:0]            o_Read_Data,
    output logic [NUM_READ_PORTS-1:0]                 o_Read_Busy,
    input  logic [NUM_WRITE_PORTS-1:0]                i_Write_Enable,
    input  logic [NUM_WRITE_PORTS*REG_ADDR_WIDTH-1:0] i_Write_Addr,
    input  logic [NUM_WRITE_PORTS*XLEN-1:0]           i_Write_Data,
    input  logic                                      i_Reserve_Enable,
    input  logic [REG_ADDR_WIDTH-1:0]                 i_Reserve_Addr,
    input  logic                                      i_Clear_Start,
    output logic                                      o_Clear_Busy,
    output logic                                      o_Clear_Done
);
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
    localparam logic [1:0] IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2;
    logic [XLEN-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [1:0] state;
    logic [REG_ADDR_WIDTH-1:0] idx;
    logic sweeping;
    assign sweeping = state == SWEEP;
    assign o_Clear_Busy = sweeping;
    assign o_Clear_Done = state == DONE;

    always_ff @(posedge i_Clock or negedge i_Reset_N)
        if (!i_Reset_N) begin
            state <= IDLE;
            idx <= '0;
        end else begin
            state <= state == IDLE ? (i_Clear_Start ? SWEEP : IDLE)
                   : state == SWEEP ? (&idx ? DONE : SWEEP) : IDLE;
            idx <= state == IDLE ? REG_ADDR_WIDTH'(1) : idx + 1'b1;
        end

    // Later write ports overwrite earlier ones; a reserve overrides any same-cycle writeback.
    always_ff @(posedge i_Clock or negedge i_Reset_N)
        if (!i_Reset_N) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
            busy <= '0;
        end else if (sweeping) begin
            regs[idx] <= '0;
            busy[idx] <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WRITE_PORTS; w++)
                if (i_Write_Enable[w] && i_Write_Addr[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0) begin
                    regs[i_Write_Addr[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] <= i_Write_Data[w*XLEN +: XLEN];
                    busy[i_Write_Addr[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] <= 1'b0;
                end
            if (i_Reserve_Enable && i_Reserve_Addr != '0)
                busy[i_Reserve_Addr] <= 1'b1;
        end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read
        logic [REG_ADDR_WIDTH-1:0] ra;
        logic [XLEN-1:0] rd;
        logic rb;
        assign ra = i_Read_Addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        always_comb begin
            rd = regs[ra];
            rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WRITE_PORTS; w++)
                if (!sweeping && i_Write_Enable[w] && i_Write_Addr[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == ra) begin
                    rd = i_Write_Data[w*XLEN +: XLEN];
                    rb = i_Reserve_Enable && i_Reserve_Addr == ra;
                end
`endif
        end
        assign o_Read_Data[p*XLEN +: XLEN] = ra == '0 ? '0 : rd;
        assign o_Read_Busy[p] = ra != '0 && rb;
    end
endmodule
